sipo_piso_master: RTL and testbench
===================================

Name: sipo_piso_master

Overview:
- Serial initiator for the sipo_piso register slave.
- Accepts parallel register read/write requests on a valid/ready interface.
- Serialises each request into a strobe-delimited frame on strobe/wr_en/din, and for reads captures the slave's reply from dout.
- Sits between on-chip control logic and the register-file slave.

Parameters:
- ADDR_WIDTH, `ADDR_WIDTH (5): register address bits.
- REG_WIDTH, `REG_WIDTH (8): register data bits.
- GAP_CYCLES, 4: idle cycles held after each frame before the next request is accepted; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  master can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  target register.
- req_wdata  in  REG_WIDTH  write data.
- rsp_valid  out  1  one-cycle pulse: frame complete.
- rsp_rdata  out  REG_WIDTH  read data; valid when rsp_valid is high after a read.
- busy  out  1  high from accept through end of gap.
- strobe  out  1  frame start pulse to slave.
- wr_en  out  1  frame direction to slave.
- din  out  1  serial data to slave.
- dout  in  1  serial data from slave.

Behaviour:
- Reset values, held while rst is high, all outputs registered:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, busy=0, strobe=0, wr_en=0, din=0.
  - FSM goes to IDLE.
  - First cycle after rst deasserts: req_ready=1.
- Reset mid-frame:
  - Frame is abandoned immediately; outputs take their reset values.
  - No rsp_valid is issued for the abandoned request.
- Frame length: N = ADDR_WIDTH + REG_WIDTH (13).
- FSM states: IDLE, SETUP, STROBE, SHIFT, GAP.
  - IDLE:
    - req_ready=1.
    - At an edge with req_valid && req_ready, capture req_write/req_addr/req_wdata, clear req_ready, set busy, go to SETUP.
    - Later changes on the request inputs are ignored.
  - SETUP (1 cycle):
    - wr_en = captured req_write; strobe=0; din=0.
  - STROBE (1 cycle):
    - strobe=1, din=0; wr_en held.
  - SHIFT (N cycles, bit counter k = 0..N-1):
    - strobe=0; wr_en held.
    - Write frame: din carries req_wdata bits 0..REG_WIDTH-1, then req_addr bits 0..ADDR_WIDTH-1, LSB first, one bit per cycle.
    - Read frame, k < ADDR_WIDTH: din = req_addr[k].
    - Read frame, k >= ADDR_WIDTH: din=0; dout is sampled at the rising edge ending cycle k into rdata bit (k-ADDR_WIDTH), LSB first.
  - GAP (GAP_CYCLES cycles):
    - din=0; wr_en held.
    - rsp_valid=1 in the first GAP cycle only.
    - On reads, rsp_rdata is loaded at the edge that enters GAP (includes the final sample). On writes, rsp_rdata is unchanged.
    - After the last GAP cycle: go to IDLE, wr_en=0, busy=0, req_ready=1.
- Timing:
  - Accept edge to strobe high: 2 edges.
  - Strobe to strobe on back-to-back requests: 2 + N + GAP_CYCLES + 1 cycles (20 with defaults).
  - rsp_valid goes high N+1 cycles after strobe goes high.
- Simultaneous events:
  - req_valid while busy is ignored; the requester holds it until req_ready is seen.
  - dout is ignored outside read sample cycles.
- Bit counter width: $clog2(N); no wrap. Leaving SHIFT at k=N-1 is mandatory.

Decomposition:
- Shared include (config.v), reused:
  - ADDR_WIDTH, REG_WIDTH.
  - Frame-length constant FRAME_LEN.
  - FSM state localparams.
- One natural sub-module: serial_shreg, a generic parameterised load/shift-right register.
  - Instance 1: the transmit frame.
  - Instance 2: read-data capture.

Test Plan:
- Reset release: check reset values; req_ready=1 one cycle after rst falls; strobe/din/wr_en stay 0 while idle.
- Write addr=3, data=0xC6:
  - wr_en=1 from SETUP; strobe high for exactly 1 cycle.
  - din = 0,1,1,0,0,0,1,1,1,1,0,0,0 over the 13 SHIFT cycles.
  - rsp_valid single pulse; rsp_rdata unchanged.
- Read addr=5 against a behavioural slave driving 0x2B LSB first in SHIFT cycles 5..12:
  - din = 1,0,1,0,0 then zeros; wr_en=0.
  - rsp_valid pulse with rsp_rdata=0x2B.
- Back-to-back with req_valid held high:
  - Requests are accepted only when req_ready=1.
  - Strobe pulses exactly 20 cycles apart.
  - One rsp_valid per request, in order.
- rst asserted in SHIFT cycle 6 of a write: all outputs go to reset values in the same cycle; no rsp_valid; next request after release runs a complete, correct frame.
- Loopback with sipo_piso:
  - Write all 17 locations (addr 0..16, including data 0xA2 @0, 0x5D @1, 0x47 @8, random data @9..16).
  - Read back each one; every rsp_rdata matches what was written.

Source files
------------

// File: rtl/sipo_piso_master_pkg.sv
// Shared widths and FSM encoding for the sipo_piso serial initiator.
package sipo_piso_master_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_REG_WIDTH  = 8;
    localparam int DEF_FRAME_LEN  = DEF_ADDR_WIDTH + DEF_REG_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_SHIFT,
        ST_GAP
    } state_t;

endpackage

// File: rtl/sipo_piso_master_shreg.sv
// Generic load / shift-right register; serial input enters at the MSB.
module sipo_piso_master_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_i,
    input  logic             shift_in_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_data_i;
        end else if (shift_i) begin
            q_d = {shift_in_i, q_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/sipo_piso_master.sv
// Serial initiator: turns parallel register requests into strobe-delimited frames.
// state  | meaning
// IDLE   | ready for a request
// SETUP  | direction presented on wr_en
// STROBE | one-cycle frame start
// SHIFT  | FRAME_LEN bits, LSB first; read replies sampled from dout
// GAP    | idle spacing, rsp_valid on first cycle
module sipo_piso_master
    import sipo_piso_master_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int REG_WIDTH  = DEF_REG_WIDTH,
    parameter int GAP_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [REG_WIDTH-1:0]  req_wdata,
    output logic                  rsp_valid,
    output logic [REG_WIDTH-1:0]  rsp_rdata,
    output logic                  busy,
    output logic                  strobe,
    output logic                  wr_en,
    output logic                  din,
    input  logic                  dout
);

    localparam int FRAME_LEN = ADDR_WIDTH + REG_WIDTH;
    localparam int CNT_W     = $clog2(FRAME_LEN);

    state_t               state_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [3:0]           gap_cnt_q;
    logic                 req_ready_q;
    logic                 rsp_valid_q;
    logic [REG_WIDTH-1:0] rsp_rdata_q;
    logic                 busy_q;
    logic                 strobe_q;
    logic                 wr_en_q;
    logic                 din_q;

    logic                 accept;
    logic [FRAME_LEN-1:0] tx_load;
    logic [FRAME_LEN-1:0] tx_q;
    logic                 tx_shift;
    logic [REG_WIDTH-1:0] rx_q;
    logic                 rx_shift;
    logic                 unused_bits;

    assign accept   = (state_q == ST_IDLE) && req_valid && req_ready_q;
    // Reads send only the address; zeros fill the reply window.
    assign tx_load  = req_write ? {req_addr, req_wdata}
                                : {{REG_WIDTH{1'b0}}, req_addr};
    assign tx_shift = (state_q == ST_STROBE) || (state_q == ST_SHIFT);
    assign rx_shift = (state_q == ST_SHIFT) && !wr_en_q
                      && (bit_cnt_q >= CNT_W'(ADDR_WIDTH));

    sipo_piso_master_shreg #(.WIDTH(FRAME_LEN)) u_tx (
        .clk         (clk),
        .rst         (rst),
        .load_i      (accept),
        .load_data_i (tx_load),
        .shift_i     (tx_shift),
        .shift_in_i  (1'b0),
        .q_o         (tx_q)
    );

    sipo_piso_master_shreg #(.WIDTH(REG_WIDTH)) u_rx (
        .clk         (clk),
        .rst         (rst),
        .load_i      (1'b0),
        .load_data_i ({REG_WIDTH{1'b0}}),
        .shift_i     (rx_shift),
        .shift_in_i  (dout),
        .q_o         (rx_q)
    );

    assign unused_bits = ^{tx_q[FRAME_LEN-1:1], rx_q[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
            strobe_q    <= 1'b0;
            wr_en_q     <= 1'b0;
            din_q       <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        wr_en_q     <= req_write;
                        state_q     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    strobe_q <= 1'b1;
                    state_q  <= ST_STROBE;
                end
                ST_STROBE: begin
                    strobe_q  <= 1'b0;
                    din_q     <= tx_q[0];
                    bit_cnt_q <= '0;
                    state_q   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bit_cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                        // The final reply bit is still on dout at this edge.
                        din_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        if (!wr_en_q) begin
                            rsp_rdata_q <= {dout, rx_q[REG_WIDTH-1:1]};
                        end
                        gap_cnt_q <= 4'(GAP_CYCLES - 1);
                        state_q   <= ST_GAP;
                    end else begin
                        din_q     <= tx_q[0];
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == 4'd0) begin
                        wr_en_q     <= 1'b0;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = busy_q;
    assign strobe    = strobe_q;
    assign wr_en     = wr_en_q;
    assign din       = din_q;

endmodule

// File: tb/tb_sipo_piso_master.sv
// Bench for sipo_piso_master: behavioural register slave plus response/frame scoreboards.
module tb_sipo_piso_master;

    localparam int AW  = 5;
    localparam int RW  = 8;
    localparam int N   = AW + RW;
    localparam int GAP = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [RW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic [RW-1:0] rsp_rdata;
    logic          busy;
    logic          strobe;
    logic          wr_en;
    logic          din;
    logic          dout = 1'b0;

    always #5 clk = ~clk;

    sipo_piso_master #(.ADDR_WIDTH(AW), .REG_WIDTH(RW), .GAP_CYCLES(GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .strobe    (strobe),
        .wr_en     (wr_en),
        .din       (din),
        .dout      (dout)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct { bit rd; logic [RW-1:0] data; } rsp_t;
    typedef struct { bit we; logic [N-1:0] bits; } frm_t;

    rsp_t          rsp_q[$];
    frm_t          frm_q[$];
    logic [RW-1:0] model_mem [32];
    logic [RW-1:0] model_hold;
    logic [RW-1:0] slave_mem [32];

    // Behavioural slave: decodes frames from strobe/din and replies on dout.
    int            s_pos = -1;
    bit            s_we;
    logic [N-1:0]  s_bits;
    frm_t          s_exp;

    always @(negedge clk) begin
        dout = 1'($urandom);
        if (rst) begin
            s_pos = -1;
        end else if (strobe) begin
            s_pos  = 0;
            s_we   = wr_en;
            s_bits = '0;
        end else if (s_pos >= 0) begin
            s_bits[s_pos] = din;
            if (!s_we && s_pos >= AW) dout = slave_mem[s_bits[AW-1:0]][s_pos-AW];
            if (s_pos == N - 1) begin
                if (s_we) slave_mem[s_bits[N-1:RW]] = s_bits[RW-1:0];
                if (frm_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL frame_unexpected: got frame %0h, expected none", s_bits);
                end else begin
                    s_exp = frm_q.pop_front();
                    check("frame_wr_en", s_we, s_exp.we);
                    check("frame_din", s_bits, s_exp.bits);
                end
                s_pos = -1;
            end else begin
                s_pos++;
            end
        end
    end

    // Response monitor.
    bit   prev_strobe = 0;
    bit   prev_rsp = 0;
    int   last_strobe = -100;
    bit   b2b_on = 0;
    int   b2b_last = -1;
    rsp_t m_exp;

    always @(negedge clk) begin
        if (rst) begin
            prev_strobe = 0;
            prev_rsp    = 0;
        end else begin
            if (strobe) begin
                check("strobe_width", prev_strobe, 0);
                check("busy_at_strobe", busy, 1);
                if (b2b_on && b2b_last >= 0) check("strobe_spacing", cyc - b2b_last, 20);
                if (b2b_on) b2b_last = cyc;
                last_strobe = cyc;
            end
            if (rsp_valid) begin
                check("rsp_single_pulse", prev_rsp, 0);
                check("rsp_latency", cyc - last_strobe, N + 1);
                if (rsp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL rsp_unexpected: got rsp_valid data %0h, expected none", rsp_rdata);
                end else begin
                    m_exp = rsp_q.pop_front();
                    if (m_exp.rd) check("rsp_rdata_read", rsp_rdata, m_exp.data);
                    else          check("rsp_rdata_write_hold", rsp_rdata, m_exp.data);
                end
            end
            prev_strobe = strobe;
            prev_rsp    = rsp_valid;
        end
    end

    task automatic push_expect(input bit we, input logic [AW-1:0] a, input logic [RW-1:0] d);
        frm_t f;
        f.we = we;
        for (int k = 0; k < N; k++) begin
            if (we) f.bits[k] = (k < RW) ? d[k] : a[k-RW];
            else    f.bits[k] = (k < AW) ? a[k] : 1'b0;
        end
        frm_q.push_back(f);
        if (we) begin
            rsp_q.push_back('{rd: 1'b0, data: model_hold});
            model_mem[a] = d;
        end else begin
            model_hold = model_mem[a];
            rsp_q.push_back('{rd: 1'b1, data: model_hold});
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge, req_valid still high.
    task automatic do_req(input bit we, input logic [AW-1:0] a, input logic [RW-1:0] d, input bit commit);
        int t = 0;
        req_valid = 1'b1;
        req_write = we;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            n_chk++;
            $display("FAIL req_accept_timeout: got req_ready 0 for %0d cycles, expected 1", t);
        end else begin
            if (commit) push_expect(we, a, d);
            @(negedge clk);
        end
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = AW'($urandom);
        req_wdata = RW'($urandom);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((rsp_q.size() != 0 || busy) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (rsp_q.size() != 0 || busy) begin
            n_chk++;
            $display("FAIL drain_timeout: got %0d pending responses, expected 0", rsp_q.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_strobe"}, strobe, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_din"}, din, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RW-1:0] d;
        int t;
        for (int i = 0; i < 32; i++) begin
            model_mem[i] = '0;
            slave_mem[i] = '0;
        end
        model_mem[5] = 8'h2B;
        slave_mem[5] = 8'h2B;
        model_hold   = '0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", req_ready, 1);
        repeat (4) begin
            @(negedge clk);
            check("idle_quiet", {strobe, din, wr_en, busy}, 4'b0000);
        end

        do_req(1'b1, 5'd3, 8'hC6, 1'b1);
        idle();
        @(negedge clk);
        check("write_wr_en_at_strobe", {strobe, wr_en}, 2'b11);
        wait_drain();

        do_req(1'b0, 5'd5, 8'h00, 1'b1);
        idle();
        wait_drain();

        b2b_on   = 1'b1;
        b2b_last = -1;
        for (int i = 0; i < 6; i++)
            do_req(1'($urandom), AW'($urandom_range(0, 16)), RW'($urandom), 1'b1);
        idle();
        wait_drain();
        b2b_on = 1'b0;

        do_req(1'b1, 5'd7, 8'h99, 1'b0);
        idle();
        t = 0;
        while (!strobe && t < 50) begin
            @(negedge clk);
            t++;
        end
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_hold = '0;
        do_req(1'b1, 5'd7, RW'($urandom), 1'b1);
        do_req(1'b0, 5'd7, 8'h00, 1'b1);
        idle();
        wait_drain();

        for (int a = 0; a <= 16; a++) begin
            d = RW'($urandom);
            if (a == 0) d = 8'hA2;
            if (a == 1) d = 8'h5D;
            if (a == 8) d = 8'h47;
            do_req(1'b1, AW'(a), d, 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                idle();
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        for (int a = 0; a <= 16; a++) do_req(1'b0, AW'(a), RW'($urandom), 1'b1);
        idle();
        wait_drain();
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
